// File: rtl/picosoc_iomem_display.sv
// picosoc_iomem_display: GPIO register on the PicoSoC iomem bus, driving
// a 4-digit multiplexed common-cathode seven-segment display, debug LEDs
// and the onboard LED. Reads return the second toggle and the up_down switch.
module picosoc_iomem_display #(
    parameter logic [23:0] SEC_RELOAD     = 24'hF423FF,
    parameter logic [23:0] REFRESH_RELOAD = 24'h000F00,
    parameter logic [7:0]  GPIO_PAGE      = 8'h03,
    parameter logic [7:0]  NULL_PAGE      = 8'h04
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        up_down,
    output logic [3:0]  dbg,
    output logic        user_led,
    output logic [3:0]  comm,
    output logic [6:0]  seg
);

    logic [31:0] r_gpio;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic [23:0] r_sec_cnt;
    logic        r_sec_toggle;
    logic [23:0] r_ref_cnt;
    logic [1:0]  r_dd;

    logic [7:0]  w_page;
    logic        w_unused;
    logic [3:0]  w_digit;
    logic [3:0]  w_comm;
    logic [6:0]  w_seg;

    // Only the page byte of the address takes part in decode.
    assign w_page   = iomem_addr[31:24];
    assign w_unused = ^iomem_addr[23:0];

    // Bus slave: one-cycle acknowledge, byte-strobed GPIO write, registered read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gpio  <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else if (r_ready) begin
            r_ready <= 1'b0;
        end else if (iomem_valid) begin
            if (w_page == GPIO_PAGE) begin
                r_ready <= 1'b1;
                r_rdata <= {30'b0, up_down, r_sec_toggle};
                for (int i = 0; i < 4; i++) begin
                    if (iomem_wstrb[i]) begin
                        r_gpio[i*8 +: 8] <= iomem_wdata[i*8 +: 8];
                    end
                end
            end else if (w_page == NULL_PAGE) begin
                r_ready <= 1'b1;
                r_rdata <= '0;
            end
        end
    end

    // Second timer: down-counter, toggles the status bit on terminal count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sec_cnt    <= SEC_RELOAD;
            r_sec_toggle <= 1'b1;
        end else if (r_sec_cnt == 24'd0) begin
            r_sec_cnt    <= SEC_RELOAD;
            r_sec_toggle <= ~r_sec_toggle;
        end else begin
            r_sec_cnt <= r_sec_cnt - 24'd1;
        end
    end

    // Refresh timer: down-counter, steps the digit index 3->2->1->0->3 as a clock enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ref_cnt <= REFRESH_RELOAD;
            r_dd      <= 2'd3;
        end else if (r_ref_cnt == 24'd0) begin
            r_ref_cnt <= REFRESH_RELOAD;
            r_dd      <= r_dd - 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt - 24'd1;
        end
    end

    // Digit select: dd=0 shows the most significant nibble on the rightmost cathode.
    always_comb begin
        w_comm  = 4'b0111;
        w_digit = r_gpio[3:0];
        case (r_dd)
            2'd0: begin w_comm = 4'b1110; w_digit = r_gpio[15:12]; end
            2'd1: begin w_comm = 4'b1101; w_digit = r_gpio[11:8];  end
            2'd2: begin w_comm = 4'b1011; w_digit = r_gpio[7:4];   end
            default: begin w_comm = 4'b0111; w_digit = r_gpio[3:0]; end
        endcase
    end

    // Segment decode for a display mounted upside-down (bit 6=g .. bit 0=a).
    always_comb begin
        w_seg = 7'b0111111;
        case (w_digit)
            4'h0: w_seg = 7'b0111111;
            4'h1: w_seg = 7'b0110000;
            4'h2: w_seg = 7'b1011011;
            4'h3: w_seg = 7'b1111001;
            4'h4: w_seg = 7'b1110100;
            4'h5: w_seg = 7'b1101101;
            4'h6: w_seg = 7'b1101111;
            4'h7: w_seg = 7'b0111000;
            4'h8: w_seg = 7'b1111111;
            4'h9: w_seg = 7'b1111100;
            4'hA: w_seg = 7'b1111110;
            4'hB: w_seg = 7'b1100111;
            4'hC: w_seg = 7'b0001111;
            4'hD: w_seg = 7'b1110011;
            4'hE: w_seg = 7'b1001111;
            4'hF: w_seg = 7'b1001110;
            default: w_seg = 7'b0111111;
        endcase
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign dbg         = r_gpio[31:28];
    assign user_led    = r_gpio[4];
    assign comm        = w_comm;
    assign seg         = w_seg;

endmodule

// File: tb/tb_picosoc_iomem_display.sv
module tb_picosoc_iomem_display;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        up_down = 1'b0;
    logic [3:0]  dbg;
    logic        user_led;
    logic [3:0]  comm;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    picosoc_iomem_display #(
        .SEC_RELOAD    (24'd9),
        .REFRESH_RELOAD(24'd3),
        .GPIO_PAGE     (8'h03),
        .NULL_PAGE     (8'h04)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .up_down    (up_down),
        .dbg        (dbg),
        .user_led   (user_led),
        .comm       (comm),
        .seg        (seg)
    );

    typedef struct {
        logic [7:0]  page;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        ud;
        logic        ack;
        logic [31:0] gpio;
    } vec_t;

    vec_t        vec [10];
    logic [6:0]  seg_tab [16];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_edges;
    logic [31:0] m_gpio = 32'h0;
    logic [31:0] m_rdata = 32'h0;

    // Edges since reset release; the timers are predicted from this alone.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) n_edges <= 0;
        else         n_edges <= n_edges + 1;
    end

    function automatic logic tog_after(input int k);
        return ((k / 10) % 2) == 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_disp();
        int dd;
        logic [3:0] nib;
        logic [3:0] exp_comm;
        dd       = 3 - ((n_edges / 4) % 4);
        exp_comm = ~(4'b0001 << dd);
        nib      = m_gpio[(3 - dd) * 4 +: 4];
        check("comm", {28'h0, comm}, {28'h0, exp_comm});
        check("seg", {25'h0, seg}, {25'h0, seg_tab[nib]});
    endtask

    task automatic access(input logic [7:0] page, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic ud,
                          input logic exp_ack, input logic [31:0] exp_gpio);
        @(posedge clk);
        #1;
        iomem_valid = 1'b1;
        iomem_addr  = {page, 24'h00_1234};
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        up_down     = ud;
        @(posedge clk);
        @(negedge clk);
        check("ack", {31'h0, iomem_ready}, {31'h0, exp_ack});
        m_gpio = exp_gpio;
        if (exp_ack) begin
            m_rdata = (page == 8'h03) ? {30'b0, ud, tog_after(n_edges - 1)} : 32'h0;
            check("rdata", iomem_rdata, m_rdata);
            check("dbg", {28'h0, dbg}, {28'h0, m_gpio[31:28]});
            check("user_led", {31'h0, user_led}, {31'h0, m_gpio[4]});
            check_disp();
            @(posedge clk);
            #1;
            iomem_valid = 1'b0;
            @(negedge clk);
            check("ack_drop", {31'h0, iomem_ready}, 32'h0);
            check("rdata_hold", iomem_rdata, m_rdata);
        end else begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                check("no_ack", {31'h0, iomem_ready}, 32'h0);
            end
            iomem_valid = 1'b0;
            check("rdata_hold", iomem_rdata, m_rdata);
            check("dbg", {28'h0, dbg}, {28'h0, m_gpio[31:28]});
            check_disp();
        end
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h30, 7'h5B, 7'h79, 7'h74, 7'h6D, 7'h6F, 7'h38,
                    7'h7F, 7'h7C, 7'h7E, 7'h67, 7'h0F, 7'h73, 7'h4F, 7'h4E};

        vec[0] = '{8'h03, 4'hF, 32'h1000_1234, 1'b0, 1'b1, 32'h1000_1234};
        vec[1] = '{8'h03, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vec[2] = '{8'h03, 4'h2, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_00FF};
        vec[3] = '{8'h03, 4'h1, 32'h0000_00A5, 1'b1, 1'b1, 32'hFFFF_00A5};
        vec[4] = '{8'h03, 4'h8, 32'h5A00_0000, 1'b0, 1'b1, 32'h5AFF_00A5};
        vec[5] = '{8'h04, 4'hF, 32'h1234_5678, 1'b1, 1'b1, 32'h5AFF_00A5};
        vec[6] = '{8'h05, 4'hF, 32'h0000_0000, 1'b1, 1'b0, 32'h5AFF_00A5};
        vec[7] = '{8'h03, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 32'h5AFF_00A5};
        vec[8] = '{8'h03, 4'hC, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_00A5};
        vec[9] = '{8'h03, 4'h3, 32'h1234_C3E9, 1'b1, 1'b1, 32'hDEAD_C3E9};

        // Reset state seen right after release.
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_dbg", {28'h0, dbg}, 32'h0);
        check("rst_led", {31'h0, user_led}, 32'h0);
        check("rst_comm", {28'h0, comm}, 32'h7);
        check("rst_seg", {25'h0, seg}, 32'h3F);

        // First read straight after reset: toggle still 1.
        access(8'h03, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        check("first_read", iomem_rdata, 32'h0000_0003);

        // Table-driven bus accesses, each followed by a full digit sweep.
        for (int v = 0; v < 10; v++) begin
            access(vec[v].page, vec[v].wstrb, vec[v].wdata, vec[v].ud, vec[v].ack, vec[v].gpio);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                check_disp();
            end
        end

        // Master holding valid is served every other cycle.
        @(posedge clk);
        #1;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'h0;
        up_down     = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("held_ack", {31'h0, iomem_ready}, {31'h0, (k % 2) == 0});
            if ((k % 2) == 0) begin
                m_rdata = {30'b0, 1'b0, tog_after(n_edges - 1)};
                check("held_rdata", iomem_rdata, m_rdata);
            end
        end
        iomem_valid = 1'b0;

        // Reset asserted while an acknowledge is pending.
        @(posedge clk);
        #1;
        iomem_valid = 1'b1;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_ack", {31'h0, iomem_ready}, 32'h1);
        check("pre_rst_dbg", {28'h0, dbg}, 32'hF);
        resetn = 1'b0;
        #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        check("mid_rst_ready", {31'h0, iomem_ready}, 32'h0);
        check("mid_rst_rdata", iomem_rdata, 32'h0);
        check("mid_rst_dbg", {28'h0, dbg}, 32'h0);
        check("mid_rst_comm", {28'h0, comm}, 32'h7);
        check("mid_rst_seg", {25'h0, seg}, 32'h3F);
        m_gpio  = 32'h0;
        m_rdata = 32'h0;
        @(negedge clk);
        resetn = 1'b1;

        // Refresh restarts: comm steps every 4 cycles from 0111.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_disp();
        end
        // Toggle has flipped once by edge 13: read with up_down=0 gives 0.
        access(8'h03, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        check("read_after_toggle", iomem_rdata, 32'h0);

        // Back-to-back reads track the 10-cycle toggle period.
        for (int j = 0; j < 10; j++) begin
            access(8'h03, 4'h0, 32'h0, j[0], 1'b1, 32'h0);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_disp();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
